conv_core_param: RTL and testbench

- Parametrised 1-D discrete convolution engine: the next-generation compute core behind the AIP convolution wrapper.
- Reads operand memories X and Y through synchronous read ports and writes result memory Z through a write port.
- Adds over the fixed-size core: selectable FULL/VALID mode, signed/unsigned arithmetic, optional saturation, error reporting and a reported result length.
- Sits between the AIP memory banks (MdataX/MdataY/MdataZ) and the config/status register (Csize, STATUS done/error bits).

---
 rtl/conv_pkg.sv | 46 ++++
 rtl/conv_core_param_mac.sv | 54 +++++
 rtl/conv_core_param.sv | 219 +++++++++++++++++++++
 tb/tb_conv_core_param.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, constants and helpers for the parametrised 1-D convolution core.
// Imported by the core top and its multiply-accumulate unit.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_MAC,
    S_WRITE,
    S_FIN
  } state_e;

  localparam logic MODE_FULL  = 1'b0;
  localparam logic MODE_VALID = 1'b1;

  localparam int CLAMP_AW = 160;
  localparam int CLAMP_DW = 64;

  function automatic int acc_w_f(input int dw, input int aw);
    return 2 * dw + aw + 1;
  endfunction

  // acc arrives already sign/zero extended to CLAMP_AW bits
  function automatic logic [CLAMP_DW-1:0] sat_clamp(
    input logic [CLAMP_AW-1:0] acc,
    input int                  dw,
    input logic                sgn
  );
    logic [CLAMP_AW-1:0] one;
    logic [CLAMP_AW-1:0] hi;
    logic [CLAMP_AW-1:0] lo;
    one = CLAMP_AW'(1);
    if (sgn) begin
      hi = (one << (dw - 1)) - one;
      lo = ~hi;
      if ($signed(acc) > $signed(hi)) return hi[CLAMP_DW-1:0];
      if ($signed(acc) < $signed(lo)) return lo[CLAMP_DW-1:0];
    end else begin
      hi = (one << dw) - one;
      if (acc > hi) return hi[CLAMP_DW-1:0];
    end
    return acc[CLAMP_DW-1:0];
  endfunction

endpackage

// File: rtl/conv_core_param_mac.sv
// Registered multiply-accumulate with clear and enable.
// Product is full precision, extended to the accumulator width per SIGNED.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = acc_w_f(32, 5),
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  localparam logic SGN = (SIGNED != 0);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  // low 2*DATA_W bits of the extended product are exact either way
  assign a_ext    = {{DATA_W{SGN & a[DATA_W-1]}}, a};
  assign b_ext    = {{DATA_W{SGN & b[DATA_W-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){SGN & prod[2*DATA_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_core_param.sv
// 1-D convolution engine: FULL/VALID, signed/unsigned, optional saturation.
// Reads X/Y through synchronous ports, writes Z one word per output index.
module conv_core_param
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SIGNED = 1,
  parameter int ACC_W  = acc_w_f(DATA_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              start,
  input  logic              mode,
  input  logic              sat_en,
  input  logic [ADDR_W:0]   size_x,
  input  logic [ADDR_W:0]   size_y,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] y_rdata,
  output logic [ADDR_W:0]   z_addr,
  output logic [DATA_W-1:0] z_wdata,
  output logic              z_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   z_len
);

  localparam int SW = ADDR_W + 1;
  localparam int IW = ADDR_W + 2;
  localparam logic [IW-1:0] MAX_LEN = IW'(1 << ADDR_W);
  localparam logic SGN = (SIGNED != 0);

  state_e st_q, st_d;
  logic [IW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic          mode_q, mode_d, sat_q, sat_d;
  logic [IW-1:0] n_q, n_d, k_q, k_d;
  logic [ADDR_W-1:0] xa_q, xa_d, ya_q, ya_d;
  logic [ADDR_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [SW-1:0] za_q, za_d, zl_q, zl_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          err_q, err_d;

  logic [IW-1:0] kmax_c, n_last, k_ld;
  logic          bad, load, mac_clr, mac_acc;
  logic [ACC_W-1:0]    acc;
  logic [CLAMP_AW-1:0] acc_ext;
  logic [CLAMP_DW-1:0] clamped;

  function automatic logic [IW-1:0] kmin_f(
    input logic [IW-1:0] n,
    input logic [IW-1:0] sy
  );
    return (n >= sy) ? n - sy + IW'(1) : '0;
  endfunction

  assign kmax_c = (n_q < sx_q) ? n_q : sx_q - IW'(1);
  assign n_last = (mode_q == MODE_VALID) ? sx_q - IW'(1)
                                         : sx_q + sy_q - IW'(2);
  assign bad = (sx_q == '0) || (sy_q == '0)
            || (sx_q > MAX_LEN) || (sy_q > MAX_LEN)
            || ((mode_q == MODE_VALID) && (sx_q < sy_q));

  always_comb begin
    st_d    = st_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    n_d     = n_q;
    k_d     = k_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    rx_d    = xa_q;
    ry_d    = ya_q;
    za_d    = za_q;
    zl_d    = zl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    load    = 1'b0;
    mac_clr = 1'b0;
    mac_acc = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          sx_d   = IW'(size_x);
          sy_d   = IW'(size_y);
          mode_d = mode;
          sat_d  = sat_en;
          busy_d = 1'b1;
          err_d  = 1'b0;
          za_d   = '0;
          st_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad) begin
          err_d = 1'b1;
          st_d  = S_FIN;
        end else begin
          n_d  = (mode_q == MODE_VALID) ? sy_q - IW'(1) : '0;
          load = 1'b1;
          st_d = S_ISSUE;
        end
      end
      S_ISSUE, S_MAC: begin
        // address runs one term ahead of the accumulator
        if (IW'(xa_q) < kmax_c) begin
          xa_d = xa_q + 1'b1;
          ya_d = ya_q - 1'b1;
        end
        if (st_q == S_ISSUE) begin
          mac_clr = 1'b1;
          st_d    = S_MAC;
        end else begin
          mac_acc = 1'b1;
          if (k_q == kmax_c) st_d = S_WRITE;
          else k_d = k_q + IW'(1);
        end
      end
      S_WRITE: begin
        za_d = za_q + 1'b1;
        if (n_q == n_last) begin
          st_d = S_FIN;
        end else begin
          n_d  = n_q + IW'(1);
          load = 1'b1;
          st_d = S_ISSUE;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        zl_d   = za_q;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    k_ld = kmin_f(n_d, sy_q);
    if (load) begin
      k_d  = k_ld;
      xa_d = ADDR_W'(k_ld);
      ya_d = ADDR_W'(n_d - k_ld);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      st_q   <= S_IDLE;
      sx_q   <= '0;
      sy_q   <= '0;
      mode_q <= 1'b0;
      sat_q  <= 1'b0;
      n_q    <= '0;
      k_q    <= '0;
      xa_q   <= '0;
      ya_q   <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      za_q   <= '0;
      zl_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (en_s) begin
      st_q   <= st_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      mode_q <= mode_d;
      sat_q  <= sat_d;
      n_q    <= n_d;
      k_q    <= k_d;
      xa_q   <= xa_d;
      ya_q   <= ya_d;
      rx_q   <= rx_d;
      ry_q   <= ry_d;
      za_q   <= za_d;
      zl_q   <= zl_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  conv_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mac (
    .clk   (clk),
    .rst_a (rst_a),
    .en    (en_s),
    .clr   (mac_clr),
    .acc_en(mac_acc),
    .a     (x_rdata),
    .b     (y_rdata),
    .acc   (acc)
  );

  assign acc_ext = {{(CLAMP_AW-ACC_W){SGN & acc[ACC_W-1]}}, acc};
  assign clamped = sat_clamp(acc_ext, DATA_W, SGN);

  // while stalled, re-present the address whose data is on rdata
  assign x_addr  = en_s ? xa_q : rx_q;
  assign y_addr  = en_s ? ya_q : ry_q;
  assign z_addr  = za_q;
  assign z_we    = (st_q == S_WRITE) && en_s;
  assign z_wdata = !z_we ? '0
                 : sat_q ? clamped[DATA_W-1:0] : acc[DATA_W-1:0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign z_len   = zl_q;

endmodule

// File: tb/tb_conv_core_param.sv
// Bench for conv_core_param: 32-bit unsigned and 8-bit signed instances
// share control; a convolution model predicts every Z write and timing.
module tb_conv_core_param;

  logic       clk = 1'b0;
  logic       rst_a, en_s, start, mode, sat_en;
  logic [5:0] size_x, size_y;

  logic [4:0]  xa32, ya32, xa8, ya8;
  logic [31:0] xr32, yr32;
  logic [7:0]  xr8, yr8;
  logic [5:0]  za32, za8, zl32, zl8;
  logic [31:0] zd32;
  logic [7:0]  zd8;
  logic        zw32, zw8, busy32, busy8, done32, done8, err32, err8;

  conv_core_param #(.DATA_W(32), .ADDR_W(5), .SIGNED(0)) u_dut32 (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .mode(mode),
    .sat_en(sat_en), .size_x(size_x), .size_y(size_y),
    .x_addr(xa32), .x_rdata(xr32), .y_addr(ya32), .y_rdata(yr32),
    .z_addr(za32), .z_wdata(zd32), .z_we(zw32), .busy(busy32),
    .done(done32), .err(err32), .z_len(zl32));

  conv_core_param #(.DATA_W(8), .ADDR_W(5), .SIGNED(1)) u_dut8 (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .mode(mode),
    .sat_en(sat_en), .size_x(size_x), .size_y(size_y),
    .x_addr(xa8), .x_rdata(xr8), .y_addr(ya8), .y_rdata(yr8),
    .z_addr(za8), .z_wdata(zd8), .z_we(zw8), .busy(busy8),
    .done(done8), .err(err8), .z_len(zl8));

  always #5 clk = ~clk;

  int          xv[32], yv[32];
  logic [31:0] xm32[32], ym32[32], zm32[64];
  logic [7:0]  xm8[32], ym8[32], zm8[64];

  always @(posedge clk) begin
    xr32 <= xm32[xa32];
    yr32 <= ym32[ya32];
    xr8  <= xm8[xa8];
    yr8  <= ym8[ya8];
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [63:0] exp32[$], exp8[$];
  int          exp_cyc;
  bit          exp_err;
  bit          armed = 1'b0;
  int          w32 = 0, w8 = 0;

  function automatic logic signed [127:0] opv(input int raw, input int dw,
                                              input bit sgn);
    logic signed [127:0] one, v;
    one = 1;
    v = {96'd0, raw};
    v = v & ((one <<< dw) - one);
    if (sgn && v[dw-1]) v = v - (one <<< dw);
    return v;
  endfunction

  function automatic logic [63:0] fmt(input logic signed [127:0] s,
                                      input int dw, input bit sgn,
                                      input bit sat);
    logic signed [127:0] one, hi, lo, v;
    one = 1;
    v = s;
    if (sat) begin
      hi = sgn ? (one <<< (dw - 1)) - one : (one <<< dw) - one;
      lo = sgn ? -(one <<< (dw - 1)) : 0;
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    v = v & ((one <<< dw) - one);
    return v[63:0];
  endfunction

  // Direct convolution sum over every (k, n-k) pair inside both operands
  task automatic build(input bit md, input int sx, input int sy,
                       input bit sat);
    logic signed [127:0] s32, s8;
    int t, lo_n, hi_n;
    exp32.delete();
    exp8.delete();
    exp_cyc = 2;
    exp_err = (sx == 0) || (sy == 0) || (sx > 32) || (sy > 32)
           || (md && sx < sy);
    if (!exp_err) begin
      lo_n = md ? sy - 1 : 0;
      hi_n = md ? sx - 1 : sx + sy - 2;
      for (int n = lo_n; n <= hi_n; n++) begin
        s32 = 0;
        s8 = 0;
        t = 0;
        for (int k = 0; k < sx; k++) begin
          if (n - k >= 0 && n - k < sy) begin
            t++;
            s32 += opv(xv[k], 32, 0) * opv(yv[n-k], 32, 0);
            s8  += opv(xv[k], 8, 1) * opv(yv[n-k], 8, 1);
          end
        end
        exp32.push_back(fmt(s32, 32, 0, sat));
        exp8.push_back(fmt(s8, 8, 1, sat));
        exp_cyc += t + 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (zw32) begin
      if (!armed || w32 >= exp32.size()) begin
        check("z_we32_unexpected", 64'(zw32), 64'd0);
      end else begin
        check("z_addr32", 64'(za32), 64'(w32));
        check("z_wdata32", 64'(zd32), exp32[w32]);
      end
      zm32[za32] = zd32;
      w32++;
    end
    if (zw8) begin
      if (!armed || w8 >= exp8.size()) begin
        check("z_we8_unexpected", 64'(zw8), 64'd0);
      end else begin
        check("z_addr8", 64'(za8), 64'(w8));
        check("z_wdata8", 64'(zd8), exp8[w8]);
      end
      zm8[za8] = zd8;
      w8++;
    end
  end

  task automatic set_mem(input int a0, a1, a2, b0, b1, b2);
    for (int i = 0; i < 32; i++) begin
      xv[i] = 0;
      yv[i] = 0;
    end
    xv[0] = a0; xv[1] = a1; xv[2] = a2;
    yv[0] = b0; yv[1] = b1; yv[2] = b2;
    for (int i = 0; i < 32; i++) begin
      xm32[i] = 32'(xv[i]);
      ym32[i] = 32'(yv[i]);
      xm8[i]  = 8'(xv[i]);
      ym8[i]  = 8'(yv[i]);
    end
  endtask

  task automatic run(input bit md, input bit sat, input int sx,
                     input int sy, input int stall_at, input int stall_len,
                     input int ign_at, input string tag, output int cyc);
    bit got;
    build(md, sx, sy, sat);
    for (int i = 0; i < 64; i++) begin
      zm32[i] = '0;
      zm8[i]  = '0;
    end
    w32 = 0;
    w8 = 0;
    armed = 1'b1;
    mode = md;
    sat_en = sat;
    size_x = 6'(sx);
    size_y = 6'(sy);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~md;
    sat_en = ~sat;
    size_x = 6'd0;
    size_y = 6'd63;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check($sformatf("%s_busy", tag), 64'(busy32), 64'd1);
      if (cyc == stall_at) en_s = 1'b0;
      if (cyc == stall_at + stall_len) en_s = 1'b1;
      start = (cyc == ign_at);
      if (done32) got = 1'b1;
    end
    start = 1'b0;
    en_s = 1'b1;
    if (!got) check($sformatf("%s_timeout", tag), 64'd0, 64'd1);
    check($sformatf("%s_cycles", tag), 64'(cyc), 64'(exp_cyc + stall_len));
    check($sformatf("%s_done8", tag), 64'(done8), 64'd1);
    check($sformatf("%s_idle", tag), 64'({busy32, busy8}), 64'd0);
    check($sformatf("%s_err32", tag), 64'(err32), 64'(exp_err));
    check($sformatf("%s_err8", tag), 64'(err8), 64'(exp_err));
    check($sformatf("%s_zlen32", tag), 64'(zl32), 64'(exp32.size()));
    check($sformatf("%s_zlen8", tag), 64'(zl8), 64'(exp8.size()));
    check($sformatf("%s_nwr32", tag), 64'(w32), 64'(exp32.size()));
    check($sformatf("%s_nwr8", tag), 64'(w8), 64'(exp8.size()));
    armed = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_zero32", tag),
          64'({xa32, ya32, za32, zd32, zw32, busy32, done32, err32, zl32}),
          64'd0);
    check($sformatf("%s_zero8", tag),
          64'({xa8, ya8, za8, zd8, zw8, busy8, done8, err8, zl8}), 64'd0);
  endtask

  initial begin
    int cyc;
    bit noisy;
    rst_a = 1'b0;
    en_s = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    sat_en = 1'b0;
    size_x = '0;
    size_y = '0;
    set_mem(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_a = 1'b1;
    @(posedge clk);
    #1;

    set_mem(1, 2, 3, 1, 1, 0);
    run(0, 0, 3, 2, -1, 0, -1, "full", cyc);
    check("full_cyc_lit", 64'(cyc), 64'd16);
    check("full_z0", 64'(zm32[0]), 64'd1);
    check("full_z1", 64'(zm32[1]), 64'd3);
    check("full_z2", 64'(zm32[2]), 64'd5);
    check("full_z3", 64'(zm32[3]), 64'd3);

    run(1, 0, 3, 2, -1, 0, -1, "valid", cyc);
    check("valid_cyc_lit", 64'(cyc), 64'd10);
    check("valid_z0", 64'(zm32[0]), 64'd3);
    check("valid_z1", 64'(zm32[1]), 64'd5);

    set_mem(127, 127, 0, 127, 127, 0);
    run(0, 1, 2, 2, -1, 0, -1, "sat", cyc);
    check("sat_z8_0", 64'(zm8[0]), 64'd127);
    check("sat_z8_1", 64'(zm8[1]), 64'd127);
    check("sat_z8_2", 64'(zm8[2]), 64'd127);
    check("sat_z32_1", 64'(zm32[1]), 64'd32258);
    run(0, 0, 2, 2, -1, 0, -1, "wrap", cyc);
    check("wrap_z8_0", 64'(zm8[0]), 64'h01);
    check("wrap_z8_1", 64'(zm8[1]), 64'h02);
    check("wrap_z8_2", 64'(zm8[2]), 64'h01);

    set_mem(-3, 5, 0, 2, -1, 0);
    run(0, 1, 2, 2, -1, 0, -1, "neg", cyc);
    check("neg_z8_1", 64'(zm8[1]), 64'h0D);

    set_mem(1, 2, 3, 1, 1, 0);
    run(0, 0, 3, 0, -1, 0, -1, "err_sy0", cyc);
    check("err_sy0_cyc_lit", 64'(cyc), 64'd2);
    check("err_sy0_flag", 64'(err32), 64'd1);
    run(1, 0, 2, 3, -1, 0, -1, "err_valid", cyc);
    run(0, 0, 33, 2, -1, 0, -1, "err_big", cyc);
    run(0, 0, 3, 2, -1, 0, -1, "clr_err", cyc);
    check("clr_err_flag", 64'(err32), 64'd0);

    run(0, 0, 3, 2, 5, 5, -1, "stall", cyc);
    check("stall_cyc_lit", 64'(cyc), 64'd21);
    check("stall_z2", 64'(zm32[2]), 64'd5);

    run(0, 0, 3, 2, -1, 0, 3, "ignore", cyc);
    check("ignore_cyc_lit", 64'(cyc), 64'd16);

    build(0, 3, 2, 0);
    w32 = 0;
    w8 = 0;
    armed = 1'b1;
    mode = 1'b0;
    sat_en = 1'b0;
    size_x = 6'd3;
    size_y = 6'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    armed = 1'b0;
    rst_a = 1'b1;
    check_zero("midrst");
    noisy = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done32 || busy32 || done8 || busy8) noisy = 1'b1;
    end
    check("midrst_quiet", 64'(noisy), 64'd0);

    run(0, 0, 3, 2, -1, 0, -1, "fresh", cyc);
    check("fresh_z3", 64'(zm32[3]), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
